// File: rtl/bar_pkg.sv
// Shared defaults, mode codes and FSM encoding for the bar height generator.
package bar_pkg;

  localparam int unsigned DEF_NUM_BARS  = 5;
  localparam int unsigned DEF_HEIGHT_W  = 7;
  localparam int unsigned DEF_STEP      = 10;
  localparam int unsigned DEF_MIN_H     = 4;
  localparam int unsigned DEF_MAX_H     = 63;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned RAND_BITS = 6;

  typedef enum logic [1:0] {
    MODE_ASC  = 2'b00,
    MODE_DESC = 2'b01,
    MODE_RAND = 2'b10,
    MODE_FLAT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GEN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Fold a raw 6-bit random value into [min_h, max_h] with a single wrap
  function automatic int unsigned rand_height(input logic [RAND_BITS-1:0] v,
                                              input int unsigned min_h,
                                              input int unsigned max_h);
    int unsigned span;
    int unsigned r;
    span = max_h - min_h;
    r    = 32'(v);
    if (r > span) r = r - (span + 32'd1);
    return min_h + r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is forced to 1 so the state never locks up.
module lfsr16
  import bar_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED_EFF;
    end else begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/bar_data_gen.sv
// Generates a set of NUM_BARS bar heights (ordered, flat or random) one element per
// cycle into a shadow array, then publishes the whole set atomically.
module bar_data_gen
  import bar_pkg::*;
#(
  parameter int unsigned NUM_BARS  = DEF_NUM_BARS,
  parameter int unsigned HEIGHT_W  = DEF_HEIGHT_W,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned MIN_H     = DEF_MIN_H,
  parameter int unsigned MAX_H     = DEF_MAX_H,
  parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         gen_req,
  input  logic [1:0]                   mode,
  output logic                         busy,
  output logic [NUM_BARS*HEIGHT_W-1:0] heights,
  output logic                         heights_valid
);

  localparam int unsigned BUS_W  = NUM_BARS * HEIGHT_W;
  localparam int unsigned IDX_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int unsigned FLAT_H = (MIN_H + MAX_H) / 2;

  function automatic logic [BUS_W-1:0] asc_pattern();
    logic [BUS_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      v[i*HEIGHT_W +: HEIGHT_W] = HEIGHT_W'((i + 32'd1) * STEP);
    end
    return v;
  endfunction

  localparam logic [BUS_W-1:0] ASC_PATTERN = asc_pattern();

  state_t           r_state;
  state_t           w_next_state;
  mode_t            r_mode;
  logic [IDX_W-1:0] r_idx;
  logic [BUS_W-1:0] r_shadow;
  logic [BUS_W-1:0] w_shadow_next;
  logic [31:0]      w_elem_val;
  logic             w_last;
  logic [15:0]      w_lfsr;
  logic             w_unused_lfsr;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Only the low bits feed the height fold; the rest just keep the sequence long
  assign w_unused_lfsr = ^w_lfsr[15:RAND_BITS];

  assign w_last = (32'(r_idx) == NUM_BARS - 32'd1);

  // Value of the element at the current index, merged into the shadow image
  always_comb begin
    w_elem_val = 32'd0;
    case (r_mode)
      MODE_ASC:  w_elem_val = (32'(r_idx) + 32'd1) * STEP;
      MODE_DESC: w_elem_val = (NUM_BARS - 32'(r_idx)) * STEP;
      MODE_RAND: w_elem_val = rand_height(w_lfsr[RAND_BITS-1:0], MIN_H, MAX_H);
      MODE_FLAT: w_elem_val = FLAT_H;
      default:   w_elem_val = 32'd0;
    endcase
    w_shadow_next = r_shadow;
    w_shadow_next[32'(r_idx)*HEIGHT_W +: HEIGHT_W] = HEIGHT_W'(w_elem_val);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (gen_req) w_next_state = GEN;
      GEN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The last GEN write and the publish to heights share one edge so no partial set is visible
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy          <= 1'b0;
      heights_valid <= 1'b0;
      heights       <= ASC_PATTERN;
      r_shadow      <= ASC_PATTERN;
      r_mode        <= MODE_ASC;
      r_idx         <= '0;
    end else begin
      busy          <= (w_next_state != IDLE);
      heights_valid <= (w_next_state == DONE);
      if ((r_state == IDLE) && gen_req) begin
        r_mode <= mode_t'(mode);
      end
      if (r_state == GEN) begin
        r_shadow <= w_shadow_next;
        r_idx    <= w_last ? '0 : r_idx + IDX_W'(1);
        if (w_last) begin
          heights <= w_shadow_next;
        end
      end
    end
  end

endmodule

// File: doc/bar_data_gen.md
BAR_DATA_GEN -- requirements
Module: bar_data_gen

Interface
REQ-001 The block SHALL provide parameter NUM_BARS, default 5, which is the number of bars generated.
REQ-002 The block SHALL provide parameter HEIGHT_W, default 7, which is the bit width of one height.
REQ-003 The block SHALL provide parameter STEP, default 10, which is the height increment for the ordered patterns.
REQ-004 The block SHALL provide parameters MIN_H = 4 and MAX_H = 63, which bound random heights inclusively.
REQ-005 The block SHALL provide parameter LFSR_SEED, default 16'hACE1, which is the LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-006 Port clk, input, 1 bit: the single system clock.
REQ-007 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port gen_req, input, 1 bit: request a new bar set, sampled on each rising clk edge.
REQ-009 Port mode, input, 2 bits: 00 ascending, 01 descending, 10 random, 11 flat.
REQ-010 Port busy, output, 1 bit: high while generation is in progress.
REQ-011 Port heights, output, NUM_BARS*HEIGHT_W bits: bar i occupies bits [i*HEIGHT_W +: HEIGHT_W].
REQ-012 Port heights_valid, output, 1 bit: one-cycle pulse when heights has been updated.

Function
REQ-013 The FSM SHALL have three states, IDLE, GEN and DONE, with these transitions:
- IDLE to GEN when gen_req=1.
- GEN to DONE after NUM_BARS cycles.
- DONE to IDLE unconditionally.
REQ-014 On accepting gen_req, mode SHALL be latched; mode changes during GEN SHALL have no effect.
REQ-015 gen_req SHALL be ignored in GEN and DONE; a request is never queued.
REQ-016 In GEN, one element per cycle SHALL be written into an internal shadow array, in index order 0..NUM_BARS-1.
REQ-017 Element values SHALL be:
- ascending: (i+1)*STEP.
- descending: (NUM_BARS-i)*STEP.
- flat: (MIN_H+MAX_H)/2, truncated.
- random: MIN_H + r, where v = lfsr[5:0], r = v if v <= MAX_H-MIN_H, else r = v-(MAX_H-MIN_H+1).
REQ-018 Computed values SHALL be truncated to HEIGHT_W bits; with default parameters no value SHALL exceed 63.
REQ-019 The 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every clk cycle in all states.
REQ-020 The LFSR SHALL never reach the all-zero state.
REQ-021 On entry to DONE, the whole shadow array SHALL be copied to heights in one cycle; heights SHALL never show a partial set.
REQ-022 heights_valid SHALL be 1 exactly in the DONE cycle, i.e. NUM_BARS+1 cycles after the edge that accepted gen_req.
REQ-023 busy SHALL be 1 in GEN and DONE and 0 in IDLE.
REQ-024 gen_req held high continuously SHALL start a new generation on the first IDLE cycle after DONE, one set every NUM_BARS+2 cycles.

Reset
REQ-025 While reset=0 the block SHALL immediately enter IDLE with busy=0 and heights_valid=0.
REQ-026 During reset, heights and the shadow array SHALL be set to the ascending pattern (10,20,30,40,50 at defaults).
REQ-027 During reset the LFSR SHALL be loaded with LFSR_SEED and the element index cleared to 0.
REQ-028 Reset asserted during GEN SHALL abort generation with no heights_valid pulse and no partial update of heights.
REQ-029 After reset deasserts, the first rising clk edge SHALL be a normal IDLE cycle.

Structure
REQ-030 A shared package bar_pkg SHALL hold:
- NUM_BARS, HEIGHT_W, STEP, MIN_H and MAX_H defaults.
- The mode codes MODE_ASC, MODE_DESC, MODE_RAND and MODE_FLAT.
- The FSM state encoding.
REQ-031 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, reset, seed (parameter) and q[15:0].
REQ-032 The heights bus SHALL connect directly to the downstream sorter's bar height register load path.

Verification
REQ-033 Reset release followed by gen_req=1 for one cycle with mode=01 -> busy=1 for 6 cycles; heights_valid pulses at cycle 6; heights = 50,40,30,20,10.
REQ-034 mode=11 request -> all five heights = 33; mode switched to 00 mid-GEN -> the result is still all 33.
REQ-035 mode=10 request at a fixed cycle after reset, repeated over 3 runs -> identical heights each run, matching a reference LFSR model, each height within 4..63.
REQ-036 gen_req held high for 20 cycles with mode=00 -> exactly 3 heights_valid pulses, spaced 7 cycles apart, with heights 10,20,30,40,50.
REQ-037 Reset asserted at GEN cycle 3 of a mode=01 run -> no heights_valid pulse; heights = 10,20,30,40,50; busy=0 within the same cycle.
REQ-038 Random stress over 10^5 cycles -> the LFSR is never 0 and no height falls outside 4..63.
